// File: rtl/pipeline_control_if.sv
`timescale 1ns/1ps
// Status from ID/EX/MEM into the pipeline controller, enables/flushes/halt/perf counters back out.
// master = core side that drives stage status; slave = the controller.
interface pipeline_control_if #(
    parameter int COUNTER_WIDTH = 32
);
    logic                     id_error;
    logic                     id_is_ebreak;
    logic [4:0]               id_rs1;
    logic [4:0]               id_rs2;
    logic                     id_uses_rs1;
    logic                     id_uses_rs2;
    logic [4:0]               ex_rd;
    logic                     ex_is_load;
    logic                     ex_branch_taken;
    logic                     mem_busy;

    logic                     pc_en;
    logic                     if_id_en;
    logic                     id_ex_en;
    logic                     ex_mem_en;
    logic                     flush_if_id;
    logic                     flush_id_ex;
    logic                     halted;
    logic                     halt_cause;
    logic [COUNTER_WIDTH-1:0] stall_cycles;
    logic [COUNTER_WIDTH-1:0] flush_events;

    modport master (
        output id_error, id_is_ebreak, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_rd, ex_is_load, ex_branch_taken, mem_busy,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, flush_if_id, flush_id_ex,
               halted, halt_cause, stall_cycles, flush_events
    );

    modport slave (
        input  id_error, id_is_ebreak, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_rd, ex_is_load, ex_branch_taken, mem_busy,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, flush_if_id, flush_id_ex,
               halted, halt_cause, stall_cycles, flush_events
    );
endinterface

// File: rtl/pipeline_control.sv
`timescale 1ns/1ps
// pipeline_control: hazard, squash and halt sequencing for the 5-stage core; enables/flushes are
// zero-latency from state+inputs, mem_busy freezes every stage, counters/halt update on the next edge.
module pipeline_control #(
    parameter int DRAIN_CYCLES  = 3,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    pipeline_control_if.slave ctl
);
    localparam int              DW         = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0]   DRAIN_INIT = DW'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [DW-1:0]            r_drain_cnt;
    logic [DW-1:0]            w_drain_cnt_nxt;
    logic                     r_halted;
    logic                     r_halt_cause;
    logic                     w_halt_cause_nxt;
    logic [COUNTER_WIDTH-1:0] r_stall_cycles;
    logic [COUNTER_WIDTH-1:0] r_flush_events;

    logic w_load_use;
    logic w_halt_req;
    logic w_stall_inc;
    logic w_flush_inc;
    logic w_pc_en;
    logic w_if_id_en;
    logic w_id_ex_en;
    logic w_ex_mem_en;
    logic w_flush_if_id;
    logic w_flush_id_ex;

    assign w_load_use = ctl.ex_is_load && (ctl.ex_rd != 5'd0) &&
                        ((ctl.id_uses_rs1 && (ctl.id_rs1 == ctl.ex_rd)) ||
                         (ctl.id_uses_rs2 && (ctl.id_rs2 == ctl.ex_rd)));
    assign w_halt_req = ctl.id_error || ctl.id_is_ebreak;

    always_comb begin
        w_state_nxt      = r_state;
        w_drain_cnt_nxt  = r_drain_cnt;
        w_halt_cause_nxt = r_halt_cause;
        w_stall_inc      = 1'b0;
        w_flush_inc      = 1'b0;
        w_pc_en          = 1'b1;
        w_if_id_en       = 1'b1;
        w_id_ex_en       = 1'b1;
        w_ex_mem_en      = 1'b1;
        w_flush_if_id    = 1'b0;
        w_flush_id_ex    = 1'b0;

        unique case (r_state)
            ST_RUN: begin
                if (ctl.mem_busy) begin
                    w_pc_en     = 1'b0;
                    w_if_id_en  = 1'b0;
                    w_id_ex_en  = 1'b0;
                    w_ex_mem_en = 1'b0;
                    w_stall_inc = 1'b1;
                end else if (ctl.ex_branch_taken) begin
                    // The ID instruction is on the wrong path, so its events are moot.
                    w_flush_if_id = 1'b1;
                    w_flush_id_ex = 1'b1;
                    w_flush_inc   = 1'b1;
                end else if (w_halt_req) begin
                    w_pc_en          = 1'b0;
                    w_if_id_en       = 1'b0;
                    w_flush_id_ex    = 1'b1;
                    w_state_nxt      = ST_DRAIN;
                    w_drain_cnt_nxt  = DRAIN_INIT;
                    w_halt_cause_nxt = ctl.id_error;
                end else if (w_load_use) begin
                    w_pc_en       = 1'b0;
                    w_if_id_en    = 1'b0;
                    w_flush_id_ex = 1'b1;
                    w_stall_inc   = 1'b1;
                end
            end

            ST_DRAIN: begin
                if (ctl.mem_busy) begin
                    w_pc_en     = 1'b0;
                    w_if_id_en  = 1'b0;
                    w_id_ex_en  = 1'b0;
                    w_ex_mem_en = 1'b0;
                    w_stall_inc = 1'b1;
                end else begin
                    w_pc_en       = 1'b0;
                    w_if_id_en    = 1'b0;
                    w_flush_id_ex = 1'b1;
                    // A zero-length drain still spends one edge here before halting.
                    if (r_drain_cnt <= DW'(1)) begin
                        w_state_nxt     = ST_HALTED;
                        w_drain_cnt_nxt = '0;
                    end else begin
                        w_drain_cnt_nxt = r_drain_cnt - DW'(1);
                    end
                end
            end

            ST_HALTED: begin
                w_pc_en     = 1'b0;
                w_if_id_en  = 1'b0;
                w_id_ex_en  = 1'b0;
                w_ex_mem_en = 1'b0;
            end

            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_drain_cnt  <= '0;
            r_halted     <= 1'b0;
            r_halt_cause <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_drain_cnt  <= w_drain_cnt_nxt;
            r_halted     <= (w_state_nxt == ST_HALTED);
            r_halt_cause <= w_halt_cause_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (w_stall_inc && !(&r_stall_cycles)) begin
                r_stall_cycles <= r_stall_cycles + COUNTER_WIDTH'(1);
            end
            if (w_flush_inc && !(&r_flush_events)) begin
                r_flush_events <= r_flush_events + COUNTER_WIDTH'(1);
            end
        end
    end

    assign ctl.pc_en        = w_pc_en;
    assign ctl.if_id_en     = w_if_id_en;
    assign ctl.id_ex_en     = w_id_ex_en;
    assign ctl.ex_mem_en    = w_ex_mem_en;
    assign ctl.flush_if_id  = w_flush_if_id;
    assign ctl.flush_id_ex  = w_flush_id_ex;
    assign ctl.halted       = r_halted;
    assign ctl.halt_cause   = r_halt_cause;
    assign ctl.stall_cycles = r_stall_cycles;
    assign ctl.flush_events = r_flush_events;
endmodule

// File: tb/tb_pipeline_control.sv
`timescale 1ns/1ps
// Bench for pipeline_control: vector table, directed drain/halt/reset/saturation sequences, random run vs model.
module tb_pipeline_control;
    localparam int DRAIN = 3;

    typedef struct packed {
        logic       err;
        logic       ebreak;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       ld;
        logic       br;
        logic       busy;
    } in_t;

    // pc, if_id, id_ex, ex_mem, flush_if_id, flush_id_ex
    typedef logic [5:0] ctl_t;
    localparam ctl_t C_RUN    = 6'b111100;
    localparam ctl_t C_BUBBLE = 6'b001101;
    localparam ctl_t C_SQUASH = 6'b111111;
    localparam ctl_t C_FROZEN = 6'b000000;

    typedef struct {
        in_t  i;
        ctl_t e;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pipeline_control_if #(.COUNTER_WIDTH(32)) pif ();
    pipeline_control_if #(.COUNTER_WIDTH(4))  pif4 ();

    pipeline_control #(.DRAIN_CYCLES(DRAIN), .COUNTER_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .ctl(pif.slave)
    );
    pipeline_control #(.DRAIN_CYCLES(DRAIN), .COUNTER_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ctl(pif4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: "mode" as plain flags and an integer of remaining drain cycles.
    bit     m_halted;
    bit     m_cause;
    int     m_drain_left;
    longint m_stall, m_flush, m_stall4, m_flush4;

    function automatic in_t mk(bit err, bit eb, logic [4:0] rs1, logic [4:0] rs2, bit u1, bit u2,
                               logic [4:0] rd, bit ld, bit br, bit busy);
        in_t x;
        x.err = err; x.ebreak = eb; x.rs1 = rs1; x.rs2 = rs2; x.u1 = u1; x.u2 = u2;
        x.rd = rd; x.ld = ld; x.br = br; x.busy = busy;
        return x;
    endfunction

    function automatic bit load_use(in_t x);
        return x.ld && (x.rd != 0) && ((x.u1 && x.rs1 == x.rd) || (x.u2 && x.rs2 == x.rd));
    endfunction

    function automatic ctl_t m_ctl(in_t x);
        if (m_halted) return C_FROZEN;
        if (m_drain_left >= 0) return x.busy ? C_FROZEN : C_BUBBLE;
        if (x.busy) return C_FROZEN;
        if (x.br) return C_SQUASH;
        if (x.err || x.ebreak || load_use(x)) return C_BUBBLE;
        return C_RUN;
    endfunction

    function automatic longint sat(longint v, longint cap);
        return (v > cap) ? cap : v;
    endfunction

    task automatic m_reset();
        m_halted = 0; m_cause = 0; m_drain_left = -1;
        m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
    endtask

    task automatic m_edge(input in_t x);
        bit running;
        bit stall_ev;
        bit flush_ev;
        if (m_halted) return;
        running  = (m_drain_left < 0);
        stall_ev = x.busy || (running && !x.br && !(x.err || x.ebreak) && load_use(x));
        flush_ev = running && !x.busy && x.br;
        if (stall_ev) begin
            m_stall  = sat(m_stall + 1, 64'hFFFF_FFFF);
            m_stall4 = sat(m_stall4 + 1, 15);
        end
        if (flush_ev) begin
            m_flush  = sat(m_flush + 1, 64'hFFFF_FFFF);
            m_flush4 = sat(m_flush4 + 1, 15);
        end
        if (!running) begin
            if (!x.busy) begin
                m_drain_left--;
                if (m_drain_left <= 0) begin
                    m_halted = 1;
                    m_drain_left = -1;
                end
            end
        end else if (!x.busy && !x.br && (x.err || x.ebreak)) begin
            m_drain_left = (DRAIN < 1) ? 1 : DRAIN;
            m_cause      = x.err;
        end
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input in_t x);
        pif.id_error = x.err;      pif4.id_error = x.err;
        pif.id_is_ebreak = x.ebreak; pif4.id_is_ebreak = x.ebreak;
        pif.id_rs1 = x.rs1;        pif4.id_rs1 = x.rs1;
        pif.id_rs2 = x.rs2;        pif4.id_rs2 = x.rs2;
        pif.id_uses_rs1 = x.u1;    pif4.id_uses_rs1 = x.u1;
        pif.id_uses_rs2 = x.u2;    pif4.id_uses_rs2 = x.u2;
        pif.ex_rd = x.rd;          pif4.ex_rd = x.rd;
        pif.ex_is_load = x.ld;     pif4.ex_is_load = x.ld;
        pif.ex_branch_taken = x.br; pif4.ex_branch_taken = x.br;
        pif.mem_busy = x.busy;     pif4.mem_busy = x.busy;
    endtask

    function automatic ctl_t dut_ctl();
        return {pif.pc_en, pif.if_id_en, pif.id_ex_en, pif.ex_mem_en, pif.flush_if_id, pif.flush_id_ex};
    endfunction

    function automatic ctl_t dut4_ctl();
        return {pif4.pc_en, pif4.if_id_en, pif4.id_ex_en, pif4.ex_mem_en, pif4.flush_if_id, pif4.flush_id_ex};
    endfunction

    // Called at posedge+1: inputs applied, compared at posedge+4, then the edge is taken.
    task automatic apply(input in_t x);
        drive(x);
        #3;
    endtask

    task automatic finish_cycle(input in_t x);
        ctl_t e;
        e = m_ctl(x);
        check("ctl", dut_ctl(), e);
        check("ctl4", dut4_ctl(), e);
        check("halted", pif.halted, m_halted);
        check("halt_cause", pif.halt_cause, m_cause);
        check("stall_cycles", pif.stall_cycles, m_stall);
        check("flush_events", pif.flush_events, m_flush);
        check("stall_cycles_w4", pif4.stall_cycles, m_stall4);
        check("flush_events_w4", pif4.flush_events, m_flush4);
        @(posedge clk);
        m_edge(x);
        #1;
    endtask

    task automatic step(input in_t x);
        apply(x);
        finish_cycle(x);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    vec_t tbl[10];
    in_t  idle;
    in_t  pat[5];

    initial begin
        checks = 0;
        errors = 0;
        idle   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[0] = '{i: idle,                                   e: C_RUN};
        tbl[1] = '{i: mk(0, 0, 0, 5, 0, 1, 5, 1, 0, 0),       e: C_BUBBLE};
        tbl[2] = '{i: mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0),       e: C_RUN};
        tbl[3] = '{i: mk(0, 0, 7, 3, 1, 0, 7, 1, 0, 0),       e: C_BUBBLE};
        tbl[4] = '{i: mk(0, 0, 7, 3, 0, 1, 7, 1, 0, 0),       e: C_RUN};
        tbl[5] = '{i: mk(0, 0, 9, 9, 1, 1, 9, 0, 0, 0),       e: C_RUN};
        tbl[6] = '{i: mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1),       e: C_FROZEN};
        tbl[7] = '{i: mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0),       e: C_SQUASH};
        tbl[8] = '{i: mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 1),       e: C_FROZEN};
        tbl[9] = '{i: mk(0, 0, 4, 0, 1, 0, 4, 1, 1, 0),       e: C_SQUASH};

        drive(idle);
        do_reset();

        // Reset state with idle inputs.
        apply(idle);
        check("reset_ctl", dut_ctl(), C_RUN);
        check("reset_halted", pif.halted, 0);
        check("reset_stall", pif.stall_cycles, 0);
        check("reset_flush", pif.flush_events, 0);
        finish_cycle(idle);

        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].i);
            check($sformatf("vec%0d", i), dut_ctl(), tbl[i].e);
            finish_cycle(tbl[i].i);
        end
        check("tbl_stall_total", pif.stall_cycles, 4);
        check("tbl_flush_total", pif.flush_events, 2);
        check("tbl_not_halted", pif.halted, 0);

        // EBREAK, then two mem_busy cycles inside DRAIN: halt five edges later.
        step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        pat[0] = idle;
        pat[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        pat[2] = pat[1];
        pat[3] = mk(0, 0, 3, 3, 1, 1, 3, 1, 1, 0);
        pat[4] = mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 5; k++) begin
            step(pat[k]);
            check($sformatf("ebreak_halted_edge%0d", k + 1), pif.halted, (k == 4) ? 1 : 0);
        end
        check("ebreak_cause", pif.halt_cause, 0);
        for (int k = 0; k < 3; k++) begin
            apply(pat[k + 1]);
            check("halted_frozen", dut_ctl(), C_FROZEN);
            finish_cycle(pat[k + 1]);
        end

        // Illegal instruction halts after DRAIN edges; reset drops halted without a clock edge.
        do_reset();
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < DRAIN; k++) step(idle);
        check("illegal_halted", pif.halted, 1);
        check("illegal_cause", pif.halt_cause, 1);
        drive(idle);
        #2 rst_n = 1'b0;
        m_reset();
        #1;
        check("async_halted", pif.halted, 0);
        check("async_cause", pif.halt_cause, 0);
        check("async_ctl", dut_ctl(), C_RUN);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset mid-DRAIN returns to RUN.
        step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        apply(idle);
        check("drain_ctl", dut_ctl(), C_BUBBLE);
        rst_n = 1'b0;
        m_reset();
        #1;
        check("drain_reset_ctl", dut_ctl(), C_RUN);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 20 mem_busy cycles: the 4-bit counter pins at 15.
        do_reset();
        for (int k = 0; k < 20; k++) step(pat[1]);
        check("sat_stall_w4", pif4.stall_cycles, 15);
        check("sat_stall_w32", pif.stall_cycles, 20);

        // Random traffic against the model, resetting once halted.
        for (int n = 0; n < 1500; n++) begin
            in_t x;
            if (m_halted && ($urandom_range(0, 3) == 0)) do_reset();
            x.err    = ($urandom_range(0, 39) == 0);
            x.ebreak = ($urandom_range(0, 39) == 0);
            x.rs1    = 5'($urandom_range(0, 3));
            x.rs2    = 5'($urandom_range(0, 3));
            x.u1     = 1'($urandom_range(0, 1));
            x.u2     = 1'($urandom_range(0, 1));
            x.rd     = 5'($urandom_range(0, 3));
            x.ld     = 1'($urandom_range(0, 1));
            x.br     = ($urandom_range(0, 5) == 0);
            x.busy   = ($urandom_range(0, 4) == 0);
            step(x);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_control.md
# pipeline_control

Central hazard and sequencing controller for the 5-stage pipelined core (IF, ID, EX, MEM, WB). It consumes the decoder's per-instruction outputs in ID and the status of the EX and memory stages. From these it drives the PC and pipeline-register enables, inserts bubbles, squashes wrong-path instructions on taken branches and jumps, and halts the core after EBREAK or an illegal instruction once all older instructions have retired. It also keeps saturating stall and flush counters for performance debugging.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 3: cycles needed for the instructions in EX, MEM and WB to retire before halt.
- `COUNTER_WIDTH`, default 32: width of the performance counters.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_error` in 1: the decoder flagged the ID instruction as invalid (SIGILL).
- `id_is_ebreak` in 1: the ID instruction is EBREAK.
- `id_rs1`, `id_rs2` in 5: source register addresses of the ID instruction.
- `id_uses_rs1`, `id_uses_rs2` in 1: the ID instruction reads the corresponding register.
- `ex_rd` in 5: destination register of the EX instruction.
- `ex_is_load` in 1: the EX instruction is a load (RAM read to rd).
- `ex_branch_taken` in 1: the EX branch or jump resolved taken; the PC must load the target.
- `mem_busy` in 1: data memory is not ready; the whole pipeline must freeze.
- `pc_en` out 1: PC register update enable.
- `if_id_en` out 1: IF/ID register load enable.
- `id_ex_en` out 1: ID/EX register load enable.
- `ex_mem_en` out 1: EX/MEM and MEM/WB register load enable.
- `flush_if_id` out 1: load a NOP into IF/ID.
- `flush_id_ex` out 1: load a NOP into ID/EX.
- `halted` out 1: the core is stopped.
- `halt_cause` out 1: 0 = EBREAK, 1 = illegal instruction; valid while `halted`.
- `stall_cycles` out COUNTER_WIDTH: count of load-use and mem_busy stall cycles.
- `flush_events` out COUNTER_WIDTH: count of taken-branch flushes.

## Operation
- States: RUN, DRAIN, HALTED. State, drain counter, `halt_cause`, `halted` and both counters are registered. Enable and flush outputs are combinational from the state and inputs.
- Default in RUN (no event): all enables 1, flushes 0.
- Priority in RUN, highest first:
  1. `mem_busy`: all enables 0, flushes 0, state unchanged; `stall_cycles` +1.
  2. `ex_branch_taken`: all enables 1, `flush_if_id` = `flush_id_ex` = 1; `flush_events` +1. Any ID event is ignored because that instruction is squashed.
  3. `id_error` or `id_is_ebreak`:
     - `pc_en` = `if_id_en` = 0, `flush_id_ex` = 1, `ex_mem_en` = 1.
     - Go to DRAIN with counter = `DRAIN_CYCLES`; latch `halt_cause` = `id_error` (`id_error` wins if both are set).
  4. Load-use hazard: `ex_is_load` && `ex_rd` != 0 && ((`id_uses_rs1` && `id_rs1` == `ex_rd`) || (`id_uses_rs2` && `id_rs2` == `ex_rd`)).
     - `pc_en` = `if_id_en` = 0, `flush_id_ex` = 1; `stall_cycles` +1.
     - The stall lasts exactly one cycle per hazard; forwarding covers the next cycle.
- DRAIN:
  - `pc_en` = `if_id_en` = 0, `flush_id_ex` = 1, `ex_mem_en` = 1.
  - Counter decrements each cycle unless `mem_busy` is set. While `mem_busy`: all enables 0, `flush_id_ex` = 0, counter holds.
  - When the counter reaches 0 on a clock edge, go to HALTED.
  - `ex_branch_taken`, `id_*` and the load-use check are ignored; only bubbles are in EX.
- HALTED: all enables 0, flushes 0, `halted` = 1. The only exit is reset.
- Counters saturate at all-ones and do not increment in HALTED.

## Timing
- Reset (async assert, sync-to-clk release): state RUN, counter 0, `halted` 0, `halt_cause` 0, `stall_cycles` 0, `flush_events` 0. With inputs idle, outputs read enables 1, flushes 0.
- Reset asserted mid-DRAIN or in HALTED returns the block to RUN immediately, without waiting for a clock edge.
- Control response is zero-latency: outputs reflect same-cycle inputs.
- EBREAK seen in ID at edge N: `halted` rises after edge N+`DRAIN_CYCLES`, plus one cycle for each `mem_busy` cycle during DRAIN.
- Counter updates take effect at the edge following the qualifying cycle.

## Test plan
- Reset then idle inputs -> all enables 1, flushes 0, `halted` 0, counters 0.
- `ex_is_load`=1, `ex_rd`=5, `id_uses_rs2`=1, `id_rs2`=5 for 1 cycle -> `pc_en`=`if_id_en`=0, `flush_id_ex`=1, `stall_cycles`=1. Repeat with `ex_rd`=0 -> no stall.
- `ex_branch_taken`=1 together with `id_is_ebreak`=1 -> both flushes 1, no DRAIN, `flush_events`=1, `halted` stays 0.
- `id_is_ebreak` pulse, then `mem_busy`=1 for 2 cycles during DRAIN -> `halted`=1 exactly 5 edges later, `halt_cause`=0; enables stay 0 afterwards.
- `id_error`=1 -> `halted` after 3 edges, `halt_cause`=1. Then assert `rst_n`=0 -> `halted` drops immediately.
- Force `stall_cycles` near all-ones (COUNTER_WIDTH=4), then 20 `mem_busy` cycles -> counter holds at 15.
